// File: rtl/uart_tx_arb_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_arb_pkg
// Shared uart definitions for the byte arbiter in front of uart_tx:
//   - arb_state_e : 2-bit FSM state encoding (IDLE/ISSUE/ARM/DRAIN)
//   - ARB_NREQ_DEF / ARB_IDW_DEF : default requester count and grant width
//   - rr_index() : requester index reached 'offset' steps after 'last'
// ---------------------------------------------------------------------------
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ARM   = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

  localparam int ARB_NREQ_DEF = 4;
  localparam int ARB_IDW_DEF  = 2;

  function automatic int rr_index(input int last, input int offset, input int nreq);
    return (last + offset) % nreq;
  endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin search. The search begins one position after
// 'last' (wrapping modulo NREQ) and the first set bit of 'valid' wins.
// Ports:
//   valid  [NREQ-1:0] in  : eligible requesters
//   last   [IDW-1:0]  in  : index of the previous winner
//   found             out : at least one requester is eligible
//   winner [IDW-1:0]  out : index of the winning requester (0 when !found)
// ---------------------------------------------------------------------------
module rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int NREQ = ARB_NREQ_DEF,
  parameter int IDW  = ARB_IDW_DEF
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  last,
  output logic            found,
  output logic [IDW-1:0]  winner
);

  logic [2*NREQ-1:0] valid_dbl;
  logic [NREQ-1:0]   valid_rot;

  // Rotating a doubled copy puts requester last+1 at bit 0, so a plain
  // lowest-bit-first scan gives the round-robin order.
  assign valid_dbl = {valid, valid};
  assign valid_rot = NREQ'(valid_dbl >> (int'(last) + 1));

  // NOTE: every output of an always_comb gets a default before any branch;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && valid_rot[i]) begin
        found  = 1'b1;
        winner = IDW'(rr_index(int'(last), i + 1, NREQ));
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// ---------------------------------------------------------------------------
// uart_tx_arb
// Round-robin arbiter feeding bytes from NREQ requesters into one uart_tx.
// FSM: IDLE -> ISSUE -> ARM -> DRAIN -> IDLE. A byte is picked in IDLE while
// the transmitter is free, issued with a one-cycle tx_en / req_ready pulse,
// then the arbiter waits one cycle for tx_busy to rise and drains until it
// falls again.
// Build option: define UART_ARB_LOCK_EN to enable message locking -- after a
// byte without req_last, only the same requester is eligible until a byte
// with req_last is issued. Without it req_last is ignored.
// Ports:
//   clk, resetn              : clock, synchronous active-low reset
//   req_valid/req_data/req_last : per-requester byte (byte i at [8i+7:8i])
//   req_ready                : one-hot accept pulse to the winner
//   tx_en, tx_data, tx_busy  : uart_tx handshake
//   grant_id                 : current or last granted requester
//   arb_busy                 : FSM is not IDLE
//   sent_count               : bytes issued since reset (wraps)
// ---------------------------------------------------------------------------
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int NREQ = ARB_NREQ_DEF,
  parameter int IDW  = ARB_IDW_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_en,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic [IDW-1:0]    grant_id,
  output logic              arb_busy,
  output logic [31:0]       sent_count
);

  // Reset value of last_grant makes requester 0 the first winner.
  localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

  arb_state_e      state_q,      state_d;
  logic            tx_en_q,      tx_en_d;
  logic [NREQ-1:0] req_ready_q,  req_ready_d;
  logic [7:0]      tx_data_q,    tx_data_d;
  logic [IDW-1:0]  grant_q,      grant_d;
  logic [IDW-1:0]  last_grant_q, last_grant_d;
  logic [31:0]     sent_count_q, sent_count_d;

  logic [NREQ-1:0] eligible;
  logic            pick_found;
  logic [IDW-1:0]  pick_id;
  logic [7:0]      pick_byte;

`ifdef UART_ARB_LOCK_EN
  logic lock_q, lock_d;
  logic pick_last;

  // While locked, only the owner of the open message may win, even if it
  // has momentarily dropped req_valid.
  assign eligible = lock_q ? (req_valid & (NREQ'(1) << last_grant_q)) : req_valid;

  always_comb begin
    pick_last = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_id == IDW'(i)) pick_last = req_last[i];
    end
  end
`else
  logic unused_req_last;

  assign eligible        = req_valid;
  assign unused_req_last = ^req_last;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .valid  (eligible),
    .last   (last_grant_q),
    .found  (pick_found),
    .winner (pick_id)
  );

  always_comb begin
    pick_byte = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_id == IDW'(i)) pick_byte = req_data[8*i +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    tx_en_d      = 1'b0;
    req_ready_d  = '0;
    tx_data_d    = tx_data_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    sent_count_d = sent_count_q;
`ifdef UART_ARB_LOCK_EN
    lock_d       = lock_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        // An externally busy transmitter blocks issue entirely.
        if (!tx_busy && pick_found) begin
          state_d      = ST_ISSUE;
          // Pulses and the count are registered here so that they are
          // visible exactly during the ISSUE cycle.
          tx_en_d      = 1'b1;
          req_ready_d  = NREQ'(1) << pick_id;
          tx_data_d    = pick_byte;
          grant_d      = pick_id;
          last_grant_d = pick_id;
          sent_count_d = sent_count_q + 32'd1;
`ifdef UART_ARB_LOCK_EN
          lock_d       = !pick_last;
`endif
        end
      end
      ST_ISSUE: state_d = ST_ARM;
      // The transmitter raises busy one cycle after tx_en; ARM lets that
      // happen before DRAIN starts looking at it.
      ST_ARM:   state_d = ST_DRAIN;
      ST_DRAIN: if (!tx_busy) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values; the reset is synchronous, so it only acts
  // on a rising edge of clk.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      tx_en_q      <= 1'b0;
      req_ready_q  <= '0;
      tx_data_q    <= '0;
      grant_q      <= '0;
      last_grant_q <= LAST_RST;
      sent_count_q <= '0;
`ifdef UART_ARB_LOCK_EN
      lock_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tx_en_q      <= tx_en_d;
      req_ready_q  <= req_ready_d;
      tx_data_q    <= tx_data_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      sent_count_q <= sent_count_d;
`ifdef UART_ARB_LOCK_EN
      lock_q       <= lock_d;
`endif
    end
  end

  assign tx_en      = tx_en_q;
  assign req_ready  = req_ready_q;
  assign tx_data    = tx_data_q;
  assign grant_id   = grant_q;
  assign arb_busy   = (state_q != ST_IDLE);
  assign sent_count = sent_count_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arb
// Bench for uart_tx_arb. Requesters are byte queues, the transmitter is a
// busy counter (busy from the cycle after tx_en, held 10*40 cycles), and the
// expected grants come from round-robin arithmetic over the requests that
// were present at the decision edge. Follows UART_ARB_LOCK_EN like the DUT.
// ---------------------------------------------------------------------------
module tb_uart_tx_arb;

  localparam int NREQ     = 4;
  localparam int IDW      = 2;
  localparam int CPB      = 40;
  localparam int BUSY_CYC = 10 * CPB;
  localparam int QDEPTH   = 256;
`ifdef UART_ARB_LOCK_EN
  localparam bit LOCK_BUILD = 1'b1;
`else
  localparam bit LOCK_BUILD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              resetn;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              tx_en;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic [IDW-1:0]    grant_id;
  logic              arb_busy;
  logic [31:0]       sent_count;

  uart_tx_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_en      (tx_en),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .grant_id   (grant_id),
    .arb_busy   (arb_busy),
    .sent_count (sent_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Requester queues: {last, data}
  logic [8:0] rq_mem [NREQ][QDEPTH];
  int         rq_head [NREQ];
  int         rq_tail [NREQ];
  logic [NREQ-1:0] hold;

  // Transmitter model
  int   busy_cnt;
  logic ext_busy;

  // Reference model
  int          m_last;
  logic        m_lock;
  logic [31:0] m_cnt;
  int          m_grant;
  logic [7:0]  m_data;
  int          since_en;
  int          stall_cnt;
  logic [NREQ-1:0] prev_valid;
  logic        prev_busy;
  logic        en_seen;
  int          n_en;
  int          ready_cnt [NREQ];
  int          grant_log [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_first(input logic [NREQ-1:0] m, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (m[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic bit any_pending();
    for (int i = 0; i < NREQ; i++) if (rq_head[i] != rq_tail[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push(input int r, input logic [7:0] d, input logic last);
    rq_mem[r][rq_tail[r]] = {last, d};
    rq_tail[r] = rq_tail[r] + 1;
  endtask

  // One clock: check outputs at the falling edge, advance the transmitter
  // model, then present the next requester state for the coming rising edge.
  task automatic cycle();
    logic            rst_edge;
    logic [NREQ-1:0] elig;
    logic [8:0]      hb;
    int              w;
    rst_edge = !resetn;
    @(negedge clk);
    en_seen = 1'b0;
    if (rst_edge) begin
      check("rst_tx_en",      32'(tx_en),      32'd0);
      check("rst_req_ready",  32'(req_ready),  32'd0);
      check("rst_tx_data",    32'(tx_data),    32'd0);
      check("rst_grant_id",   32'(grant_id),   32'd0);
      check("rst_arb_busy",   32'(arb_busy),   32'd0);
      check("rst_sent_count", sent_count,      32'd0);
      m_last = NREQ - 1; m_lock = 1'b0; m_cnt = '0; m_grant = 0; m_data = '0;
      since_en = 100; stall_cnt = 0;
    end else begin
      elig = prev_valid;
      if (LOCK_BUILD && m_lock) elig = elig & (NREQ'(1) << m_last);
      if (tx_en) begin
        en_seen = 1'b1;
        n_en++;
        check("en_gap_ge4",      32'(since_en >= 4), 32'd1);
        check("en_while_busy",   32'(prev_busy),     32'd0);
        check("en_has_request",  32'(elig != '0),    32'd1);
        check("arb_busy_issue",  32'(arb_busy),      32'd1);
        w = rr_first(elig, m_last);
        if (w < 0) w = 0;
        check("ready_onehot", 32'(req_ready), 32'(NREQ'(1) << w));
        hb = (rq_head[w] != rq_tail[w]) ? rq_mem[w][rq_head[w]] : 9'h0;
        if (rq_head[w] != rq_tail[w]) rq_head[w] = rq_head[w] + 1;
        m_last = w; m_grant = w; m_data = hb[7:0]; m_lock = !hb[8];
        m_cnt = m_cnt + 32'd1;
        grant_log.push_back(int'(grant_id));
        since_en = 0; stall_cnt = 0;
      end else begin
        since_en++;
        check("ready_quiet", 32'(req_ready), 32'd0);
        if (since_en == 1) check("arb_busy_arm", 32'(arb_busy), 32'd1);
        if (!prev_busy && elig != '0 && since_en >= 2) stall_cnt++;
        else stall_cnt = 0;
        if (stall_cnt > 3) begin
          check("no_stall", 32'd0, 32'd1);
          stall_cnt = 0;
        end
      end
      check("grant_id",   32'(grant_id), 32'(m_grant));
      check("tx_data",    32'(tx_data),  32'(m_data));
      check("sent_count", sent_count,    m_cnt);
    end
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) ready_cnt[i]++;
    if (en_seen) busy_cnt = BUSY_CYC;
    else if (busy_cnt > 0) busy_cnt--;
    tx_busy = (busy_cnt != 0) || ext_busy;
    for (int i = 0; i < NREQ; i++) begin
      if (rq_head[i] != rq_tail[i] && !hold[i]) begin
        req_valid[i]      = 1'b1;
        req_data[8*i +: 8] = rq_mem[i][rq_head[i]][7:0];
        req_last[i]       = rq_mem[i][rq_head[i]][8];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
    prev_valid = req_valid;
    prev_busy  = tx_busy;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic wait_en(input int budget, input string name);
    int k = 0;
    do begin
      cycle();
      k++;
    end while (!en_seen && k < budget);
    check({name, "_tx_en_seen"}, 32'(en_seen), 32'd1);
  endtask

  task automatic wait_quiet();
    int k = 0;
    while ((busy_cnt != 0 || any_pending()) && k < 40000) begin
      cycle();
      k++;
    end
    check("drain_in_time", 32'(k < 40000), 32'd1);
    run(4);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
    cycle();
  endtask

  int s, n0;
  int exp34 [5];
  int rc0 [NREQ];

  initial begin
    resetn = 1'b0; hold = '0; ext_busy = 1'b0; busy_cnt = 0; tx_busy = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;
    prev_valid = '0; prev_busy = 1'b0; n_en = 0;
    m_last = NREQ - 1; m_lock = 1'b0; m_cnt = '0; m_grant = 0; m_data = '0;
    since_en = 100; stall_cnt = 0;
    for (int i = 0; i < NREQ; i++) begin
      rq_head[i] = 0; rq_tail[i] = 0; ready_cnt[i] = 0;
    end

    run(3);
    resetn = 1'b1;
    run(2);

    // Single byte 0x55 from requester 0
    n0 = n_en;
    push(0, 8'h55, 1'b1);
    wait_en(20, "single");
    check("single_tx_data",    32'(tx_data),   32'h55);
    check("single_req_ready",  32'(req_ready), 32'h1);
    check("single_grant_id",   32'(grant_id),  32'd0);
    check("single_sent_count", sent_count,     32'd1);
    wait_quiet();
    check("single_one_tx_en",  32'(n_en - n0), 32'd1);

    // Four requesters, two bytes each, all valid together
    do_reset();
    s = grant_log.size();
    for (int i = 0; i < NREQ; i++) rc0[i] = ready_cnt[i];
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < NREQ; i++) push(i, 8'($urandom), 1'b1);
    for (int k = 0; k < 8; k++) wait_en(BUSY_CYC + 20, "rr8");
    for (int k = 0; k < 8; k++) check("rr8_order", 32'(grant_log[s + k]), 32'(k % 4));
    for (int i = 0; i < NREQ; i++) check("rr8_ready_cnt", 32'(ready_cnt[i] - rc0[i]), 32'd2);
    wait_quiet();

    // Three-byte message from requester 2 with requester 1 competing
    do_reset();
`ifdef UART_ARB_LOCK_EN
    exp34 = '{2, 2, 2, 1, 1};
`else
    exp34 = '{2, 1, 2, 1, 2};
`endif
    s = grant_log.size();
    push(2, 8'hA0, 1'b0); push(2, 8'hA1, 1'b0); push(2, 8'hA2, 1'b1);
    wait_en(20, "msg_first");
    push(1, 8'hB0, 1'b1); push(1, 8'hB1, 1'b1);
    for (int k = 0; k < 4; k++) wait_en(BUSY_CYC + 20, "msg");
    for (int k = 0; k < 5; k++) check("msg_order", 32'(grant_log[s + k]), 32'(exp34[k]));
    wait_quiet();

    // Transmitter busy from outside: requester 3 waits, then goes promptly
    n0 = n_en;
    ext_busy = 1'b1;
    push(3, 8'hA3, 1'b1);
    run(30);
    check("ext_busy_no_tx_en", 32'(n_en - n0), 32'd0);
    ext_busy = 1'b0;
    wait_en(2, "ext_release");
    check("ext_release_grant", 32'(grant_id), 32'd3);
    check("ext_release_data",  32'(tx_data),  32'hA3);
    wait_quiet();

    // Requester 1 withdraws its request while the arbiter is idle
    n0 = n_en;
    ext_busy = 1'b1;
    push(1, 8'h3C, 1'b1);
    run(5);
    hold[1] = 1'b1;
    run(3);
    ext_busy = 1'b0;
    run(20);
    check("withdrawn_no_tx_en", 32'(n_en - n0), 32'd0);
    hold[1] = 1'b0;
    wait_en(4, "withdrawn_return");
    check("withdrawn_return_grant", 32'(grant_id), 32'd1);
    wait_quiet();

    // Reset during DRAIN with another byte pending
    push(0, 8'h81, 1'b1);
    wait_en(20, "mid_reset_byte");
    run(20);
    push(2, 8'h42, 1'b1);
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
    n0 = n_en;
    while (busy_cnt > 0) cycle();
    check("mid_reset_no_tx_en_while_busy", 32'(n_en - n0), 32'd0);
    wait_en(4, "mid_reset_resume");
    check("mid_reset_resume_grant", 32'(grant_id), 32'd2);
    check("mid_reset_resume_data",  32'(tx_data),  32'h42);
    check("mid_reset_resume_count", sent_count,    32'd1);
    wait_quiet();

    // Counter wrap
    force dut.sent_count_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    cycle();
    release dut.sent_count_q;
    cycle();
    check("wrap_preload", sent_count, 32'hFFFF_FFFF);
    push(1, 8'hEE, 1'b1);
    wait_en(20, "wrap");
    check("wrap_sent_count", sent_count, 32'd0);
    wait_quiet();

    // Randomized messages from random requesters at random times
    for (int m = 0; m < 20; m++) begin
      int r, len;
      r   = int'($urandom_range(NREQ - 1, 0));
      len = int'($urandom_range(3, 1));
      for (int b = 0; b < len; b++) push(r, 8'($urandom), (b == len - 1));
      run(int'($urandom_range(200, 0)));
    end
    wait_quiet();
    check("random_all_sent", 32'(any_pending()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of byte requesters (2..8).
REQ-002 SHALL have parameter IDW, default 2, grant index width (>= clog2(NREQ)).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester byte available.
REQ-006 SHALL have port req_data  input  8*NREQ  per-requester byte; requester i uses bits [8i+7:8i].
REQ-007 SHALL have port req_last  input  NREQ  byte is the final byte of a message.
REQ-008 SHALL have port req_ready  output  NREQ  one-hot byte-accept pulse.
REQ-009 SHALL have port tx_en  output  1  start pulse to uart_tx (uart_tx_en).
REQ-010 SHALL have port tx_data  output  8  byte to uart_tx (uart_tx_data).
REQ-011 SHALL have port tx_busy  input  1  uart_tx_busy from the transmitter.
REQ-012 SHALL have port grant_id  output  IDW  index of the current or last granted requester.
REQ-013 SHALL have port arb_busy  output  1  high whenever the FSM is not IDLE.
REQ-014 SHALL have port sent_count  output  32  bytes issued since reset.

Function
REQ-015 SHALL implement FSM IDLE -> ISSUE -> ARM -> DRAIN -> IDLE.
REQ-016 IDLE: when tx_busy=0 and any eligible req_valid is high, SHALL pick a winner, latch its byte into tx_data and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-017 ISSUE: SHALL assert tx_en and req_ready[winner] for exactly one cycle, increment sent_count by 1 (wrapping at 2^32), and go to ARM.
REQ-018 ARM: SHALL wait exactly one cycle for tx_busy to rise, then go to DRAIN.
REQ-019 DRAIN: SHALL stay until tx_busy=0, then go to IDLE; the minimum gap between tx_en pulses SHALL be 4 cycles.
REQ-020 Arbitration SHALL be round-robin: the search starts at last_grant+1 modulo NREQ, and the first valid requester wins.
REQ-021 Only the winner's req_ready SHALL pulse; losers' valid/data SHALL be held unchanged and not consumed.
REQ-022 tx_data and grant_id SHALL remain stable from ISSUE until the next IDLE win.
REQ-023 A requester that drops req_valid while in IDLE SHALL not be granted, and no glitch pulse SHALL occur.
REQ-024 If tx_busy is already high in IDLE (external transmitter use), the block SHALL not issue.

Reset
REQ-025 While resetn=0 at a clock edge, the block SHALL set: FSM=IDLE, tx_en=0, req_ready=0, tx_data=0, grant_id=0, arb_busy=0, sent_count=0, last_grant=NREQ-1 (requester 0 wins first), lock cleared.
REQ-026 Reset asserted mid-byte (ARM/DRAIN) SHALL abandon the byte, and on release SHALL return to IDLE and wait for tx_busy=0.

Configuration
REQ-027 Macro UART_ARB_LOCK_EN SHALL control message locking.
REQ-028 With UART_ARB_LOCK_EN defined: after a grant with req_last=0, only that requester SHALL be eligible until a byte with req_last=1 is issued; other requesters SHALL wait even if the locked requester deasserts valid.
REQ-029 Without UART_ARB_LOCK_EN: req_last SHALL be ignored and arbitration SHALL run per byte.

Structure
REQ-030 The shared uart definitions package SHALL hold the FSM state encodings (2-bit) and the default NREQ/IDW.
REQ-031 The round-robin search SHALL be the sub-module rr_pick (inputs: valid mask, last index; outputs: found, winner index).

Verification (uart_tx model: busy rises 1 cycle after en, held 10*cycles_per_bit, cycles_per_bit=40)
REQ-032 Single requester 0 sends 0x55: exactly one tx_en with tx_data=0x55, req_ready[0] pulses in the same cycle, sent_count=1.
REQ-033 All 4 requesters valid continuously for 8 bytes: grant order is 0,1,2,3,0,1,2,3 and each req_ready pulses once per byte.
REQ-034 LOCK_EN build: requester 2 sends a 3-byte message with last on byte 3 while requester 1 is valid: bytes issue 2,2,2, then 1; non-lock build: issue 2,1,2,1,2.
REQ-035 resetn=0 for 1 cycle during DRAIN: all outputs are 0 the next cycle, and no tx_en occurs until tx_busy falls.
REQ-036 tx_busy forced high externally with requester 3 valid: no tx_en occurs; after release, tx_en occurs within 2 cycles with grant_id=3.
REQ-037 sent_count preloaded via force to 0xFFFFFFFF, then one byte sent: sent_count=0.
